// File: rtl/ctrl_pkg.sv
// Shared codes for the multicycle ARM-subset controller: FSM states, datapath
// select encodings, condition field codes and the ALU command decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // Op field values; ImmSrc is driven straight from Op, so these double as ImmSrc codes
    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] resultsrc;
        logic [1:0] alusrcb;
        logic [1:0] alucontrol;
    } ctrl_t;

    localparam ctrl_t FETCH_CTRL = '{
        pcwrite:    1'b1,
        adrsrc:     1'b0,
        memwrite:   1'b0,
        irwrite:    1'b1,
        regwrite:   1'b0,
        alusrca:    1'b1,
        resultsrc:  RES_ALURES,
        alusrcb:    SRCB_FOUR,
        alucontrol: ALU_ADD
    };

    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and condition check. Conditional execution is compiled
// in with COND_EXEC_EN; otherwise CondEx is tied high but flags still update.
import ctrl_pkg::*;

module cond_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic       flagupd,
    input  logic       arith,
    output logic       condex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

`ifdef COND_EXEC_EN
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^{cond, n, z, c, v};
    assign condex      = 1'b1;
`endif

    // NZ always follow a flag-setting op; CV only for ADD/SUB so logical ops keep them
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= FLAGS_RST;
        end else if (flagupd && condex) begin
            flags[3:2] <= aluflags[3:2];
            if (arith) begin
                flags[1:0] <= aluflags[1:0];
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM, instruction decode and registered
// datapath strobes. Optional conditional execution via COND_EXEC_EN.
import ctrl_pkg::*;

module multicycle_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       rd_pc;
    logic       condex;
    logic       flagupd;
    logic       unused_rn;

    state_t state, nxt;
    ctrl_t  ctl, nctl;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign rd_pc     = (rd == 4'hF);
    assign unused_rn = ^Instr[7:4];

    assign flagupd = ((state == EXECR) || (state == EXECI)) && funct[0];

    cond_unit #(
        .FLAGS_RST(FLAGS_RST)
    ) u_cond (
        .clk     (clk),
        .reset   (reset),
        .cond    (cond),
        .aluflags(ALUFlags),
        .flagupd (flagupd),
        .arith   (is_arith(funct[4:1])),
        .condex  (condex)
    );

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   nxt = funct[5] ? EXECI : EXECR;
                    OP_MEM:  nxt = MEMADR;
                    OP_BR:   nxt = BRANCH;
                    default: nxt = FETCH;
                endcase
            end
            MEMADR: nxt = funct[0] ? MEMRD : MEMWR;
            MEMRD:  nxt = MEMWB;
            EXECR:  nxt = ALUWB;
            EXECI:  nxt = ALUWB;
            default: nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so CondEx is sampled one cycle
    // ahead; flags only change on the EXEC->ALUWB edge, which still sees the old value.
    always_comb begin
        nctl = '0;
        case (nxt)
            FETCH: nctl = FETCH_CTRL;
            DECODE: begin
                nctl.alusrca    = 1'b1;
                nctl.alusrcb    = SRCB_FOUR;
                nctl.alucontrol = ALU_ADD;
            end
            MEMADR: begin
                nctl.alusrcb    = SRCB_IMM;
                nctl.alucontrol = funct[3] ? ALU_ADD : ALU_SUB;
            end
            MEMRD: nctl.adrsrc = 1'b1;
            MEMWB: begin
                nctl.resultsrc = RES_DATA;
                nctl.regwrite  = condex;
                nctl.pcwrite   = condex & rd_pc;
            end
            MEMWR: begin
                nctl.adrsrc   = 1'b1;
                nctl.memwrite = condex;
            end
            EXECR: begin
                nctl.alusrcb    = SRCB_REG;
                nctl.alucontrol = alu_decode(funct[4:1]);
            end
            EXECI: begin
                nctl.alusrcb    = SRCB_IMM;
                nctl.alucontrol = alu_decode(funct[4:1]);
            end
            ALUWB: begin
                nctl.resultsrc = RES_ALUOUT;
                nctl.regwrite  = condex;
                nctl.pcwrite   = condex & rd_pc;
            end
            BRANCH: begin
                nctl.alusrca    = 1'b1;
                nctl.alusrcb    = SRCB_IMM;
                nctl.resultsrc  = RES_ALURES;
                nctl.alucontrol = ALU_ADD;
                nctl.pcwrite    = condex;
            end
            default: nctl = FETCH_CTRL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= FETCH_CTRL;
        end else begin
            state <= nxt;
            ctl   <= nctl;
        end
    end

    // Architectural writes are suppressed combinationally so an aborted
    // instruction cannot commit during the reset cycle itself.
    assign PCWrite    = ctl.pcwrite;
    assign AdrSrc     = ctl.adrsrc;
    assign MemWrite   = ctl.memwrite & ~reset;
    assign IRWrite    = ctl.irwrite;
    assign RegWrite   = ctl.regwrite & ~reset;
    assign ALUSrcA    = ctl.alusrca;
    assign ResultSrc  = ctl.resultsrc;
    assign ALUSrcB    = ctl.alusrcb;
    assign ALUControl = ctl.alucontrol;

    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and random instruction streams checked cycle by cycle against an
// instruction-level model of the controller's strobes and flag behaviour.
module tb_multicycle_controller;

    localparam logic [3:0] FRST = 4'b0110;
`ifdef COND_EXEC_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    localparam logic [11:0] M_ALL = 12'hFFF;
    localparam logic [11:0] M_STB = 12'hB80;
    localparam logic [11:0] M_ADR = 12'h400;
    localparam logic [11:0] M_SA  = 12'h040;
    localparam logic [11:0] M_RS  = 12'h030;
    localparam logic [11:0] M_SB  = 12'h00C;
    localparam logic [11:0] M_AC  = 12'h003;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    int          nchecks = 0;
    int          nerrors = 0;
    logic [3:0]  mflags;
    logic [11:0] qe[$];
    logic [11:0] qm[$];
    string       qn[$];

    always #5 clk = ~clk;

    multicycle_controller #(
        .FLAGS_RST(FRST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ResultSrc (ResultSrc),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl)
    );

    function automatic logic [11:0] vec(input bit pcw, input bit adr, input bit mw,
                                        input bit irw, input bit rw, input bit sa,
                                        input logic [1:0] rs, input logic [1:0] sb,
                                        input logic [1:0] ac);
        return {pcw, adr, mw, irw, rw, sa, rs, sb, ac};
    endfunction

    function automatic logic [11:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                ResultSrc, ALUSrcB, ALUControl};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] cnd, input logic [1:0] op,
                                       input logic [5:0] fn, input logic [3:0] rd);
        return {cnd, op, fn, 4'h0, rd};
    endfunction

    function automatic bit cond_pass(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (!CE) return 1'b1;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input logic [11:0] e, input logic [11:0] m, input string n);
        qe.push_back(e);
        qm.push_back(m);
        qn.push_back(n);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp, input logic [11:0] mask);
        nchecks++;
        assert ((obs & mask) === (exp & mask)) else begin
            nerrors++;
            $error("FAIL %s: observed=%h expected=%h mask=%h", tag, obs & mask, exp & mask, mask);
        end
    endtask

    // Entered and left at a falling edge while the controller shows FETCH.
    task automatic run_instr(input string tag, input logic [19:0] ins, input logic [3:0] af);
        logic [3:0] cnd, cmd;
        logic [1:0] op, ac;
        logic [5:0] fn;
        bit         p, rdpc;
        cnd  = ins[19:16];
        op   = ins[15:14];
        fn   = ins[13:8];
        cmd  = fn[4:1];
        rdpc = (ins[3:0] == 4'hF);
        p    = cond_pass(cnd, mflags);
        ac   = (cmd == 4'b0100) ? 2'd0 : (cmd == 4'b0010) ? 2'd1 :
               (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 : 2'd0;
        qe.delete(); qm.delete(); qn.delete();
        push(vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00), M_ALL, "fetch");
        push(vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00), M_STB | M_SA | M_SB | M_AC, "decode");
        case (op)
            2'b00: begin
                push(vec(0, 0, 0, 0, 0, 0, 2'b00, fn[5] ? 2'b01 : 2'b00, ac),
                     M_STB | M_SB | M_AC, "exec");
                push(vec(p && rdpc, 0, 0, 0, p, 0, 2'b00, 2'b00, 2'b00), M_STB | M_RS, "aluwb");
            end
            2'b01: begin
                push(vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, fn[3] ? 2'b00 : 2'b01),
                     M_STB | M_SB | M_AC, "memadr");
                if (fn[0]) begin
                    push(vec(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), M_STB | M_ADR, "memrd");
                    push(vec(p && rdpc, 0, 0, 0, p, 0, 2'b01, 2'b00, 2'b00), M_STB | M_RS, "memwb");
                end else begin
                    push(vec(0, 1, p, 0, 0, 0, 2'b00, 2'b00, 2'b00), M_STB | M_ADR, "memwr");
                end
            end
            2'b10: push(vec(p, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00),
                        M_STB | M_SA | M_RS | M_SB, "branch");
            default: ;
        endcase
        Instr    = ins;
        ALUFlags = af;
        #1;
        chk({tag, "/immsrc_regsrc"}, {8'h00, ImmSrc, RegSrc},
            {8'h00, op, (op == 2'b01) && !fn[0], op == 2'b10}, 12'h00F);
        for (int unsigned i = 0; i < qe.size(); i++) begin
            if (i != 0) @(negedge clk);
            chk({tag, "/", qn[i]}, observed(), qe[i], qm[i]);
        end
        @(negedge clk);
        if (op == 2'b00 && fn[0] && p) begin
            mflags[3:2] = af[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = af[1:0];
        end
    endtask

    initial begin
        logic [19:0] ins;
        logic [3:0]  af;
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mflags = FRST;
        chk("reset_fetch", observed(), vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00), M_ALL);

        run_instr("beq_rstflags", mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("add_imm",      mk(4'hE, 2'b00, 6'b101000, 4'h1), 4'hF);
        run_instr("ldr",          mk(4'hE, 2'b01, 6'b011001, 4'h2), 4'h0);
        run_instr("subs_z",       mk(4'hE, 2'b00, 6'b100101, 4'h3), 4'b0100);
        run_instr("beq_taken",    mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("subs_nz",      mk(4'hE, 2'b00, 6'b100101, 4'h3), 4'b0000);
        run_instr("beq_nottaken", mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("subs_z2",      mk(4'hE, 2'b00, 6'b100101, 4'h3), 4'b0100);
        run_instr("str_ne",       mk(4'h1, 2'b01, 6'b011000, 4'h4), 4'h0);
        run_instr("ldr_sub_ofs",  mk(4'hE, 2'b01, 6'b010001, 4'h2), 4'h0);
        run_instr("adds_cv",      mk(4'hE, 2'b00, 6'b101001, 4'h5), 4'b0011);
        run_instr("orrs",         mk(4'hE, 2'b00, 6'b111001, 4'h6), 4'b1100);
        run_instr("bvs",          mk(4'h6, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("bcc",          mk(4'h3, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("bmi",          mk(4'h4, 2'b10, 6'b100000, 4'h0), 4'h0);
        run_instr("op11",         mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'h0);
        run_instr("andr",         mk(4'hE, 2'b00, 6'b000000, 4'h7), 4'h0);
        run_instr("add_pc",       mk(4'hE, 2'b00, 6'b101000, 4'hF), 4'h0);
        run_instr("ldr_pc",       mk(4'hE, 2'b01, 6'b011001, 4'hF), 4'h0);
        run_instr("cond_nv",      mk(4'hF, 2'b00, 6'b101000, 4'h1), 4'h0);

        // Abort an LDR in MEMRD; FLAGS_RST has Z=1, which the following BEQ observes.
        run_instr("subs_clr", mk(4'hE, 2'b00, 6'b100101, 4'h3), 4'b0000);
        Instr = mk(4'hE, 2'b01, 6'b011001, 4'h2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_memrd", observed(), vec(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), M_STB | M_ADR);
        @(negedge clk);
        chk("rst_memrd_fetch", observed(), vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00), M_ALL);
        reset  = 1'b0;
        mflags = FRST;
        run_instr("beq_after_rst", mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);

        // A committed store must be withdrawn while reset is high.
        Instr = mk(4'hE, 2'b01, 6'b011000, 4'h4);
        repeat (3) @(negedge clk);
        chk("memwr_before_rst", observed(), vec(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00), M_STB | M_ADR);
        reset = 1'b1;
        #1;
        chk("memwr_in_rst", observed(), vec(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), M_STB);
        @(negedge clk);
        chk("rst_memwr_fetch", observed(), vec(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00), M_ALL);
        reset  = 1'b0;
        mflags = FRST;

        for (int unsigned i = 0; i < 200; i++) begin
            ins = 20'($urandom);
            af  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            run_instr("rnd", ins, af);
        end

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
